// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: width helper and defaults.
package debounce_pkg;

    localparam int DB_STABLE_TICKS_DEFAULT = 4;
    localparam int DB_PRESCALE_DEFAULT     = 1;

    // Bits needed to hold 0..n-1, never less than one so counters always exist.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, stability counter, level and edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DB_STABLE_TICKS_DEFAULT
) (
    input  logic Clk,
    input  logic Rst,
    input  logic tick,
    input  logic in_raw,
    output logic Out,
    output logic Rise,
    output logic Fall
);

    localparam int CW = clog2_min1(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clock domain; only s2 feeds the logic.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in_raw;
            s2 <= s1;
        end
    end

    // Any sample matching Out restarts the window at clock resolution; a full window of differing ticks toggles Out.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt  <= '0;
            Out  <= 1'b0;
            Rise <= 1'b0;
            Fall <= 1'b0;
        end else begin
            Rise <= 1'b0;
            Fall <= 1'b0;
            if (s2 == Out) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    Out  <= s2;
                    cnt  <= '0;
                    Rise <= s2;
                    Fall <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Debouncer for CHANNELS independent inputs sharing one sample-tick prescaler.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int STABLE_TICKS = DB_STABLE_TICKS_DEFAULT,
    parameter int PRESCALE     = DB_PRESCALE_DEFAULT
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [CHANNELS-1:0] In,
    output logic [CHANNELS-1:0] Out,
    output logic [CHANNELS-1:0] Rise,
    output logic [CHANNELS-1:0] Fall
);

    localparam int PW = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;
    logic          tick;

    // With PRESCALE=1 the counter sits at 0 == PS_LAST, so tick is constantly high.
    assign tick = (pcnt == PS_LAST);

    // Free-running sample prescaler, wrapping after PRESCALE cycles.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pcnt <= '0;
        end else if (pcnt == PS_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .Clk   (Clk),
            .Rst   (Rst),
            .tick  (tick),
            .in_raw(In[i]),
            .Out   (Out[i]),
            .Rise  (Rise[i]),
            .Fall  (Fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: instance a (PRESCALE=1, STABLE_TICKS=4), instance b (PRESCALE=5, STABLE_TICKS=3).
module tb_debounce_multi;

    logic       Clk;
    logic       Rst;
    logic [3:0] in_a, out_a, rise_a, fall_a;
    logic [3:0] in_b, out_b, rise_b, fall_b;
    logic       checking;

    int tests_run;
    int tests_failed;

    // Reference model state, index 0 = instance a, 1 = instance b.
    int         k [2];
    logic [3:0] h1 [2];
    logic [3:0] h2 [2];
    logic [3:0] m_out [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    int         run_start [2][4];

    debounce_multi #(
        .CHANNELS(4), .STABLE_TICKS(4), .PRESCALE(1)
    ) dut_a (
        .Clk(Clk), .Rst(Rst), .In(in_a), .Out(out_a), .Rise(rise_a), .Fall(fall_a)
    );

    debounce_multi #(
        .CHANNELS(4), .STABLE_TICKS(3), .PRESCALE(5)
    ) dut_b (
        .Clk(Clk), .Rst(Rst), .In(in_b), .Out(out_b), .Rise(rise_b), .Fall(fall_b)
    );

    // 10 ns system clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        tests_run++;
        if (actual < lo || actual > hi) begin
            tests_failed++;
            $display("[TB] FAIL %s actual=%0d expected=%0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic applyStimulus(input int inst, input logic [3:0] value);
        @(posedge Clk);
        #3;
        if (inst == 0) in_a = value;
        else           in_b = value;
    endtask

    task automatic waitEdge(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic modelReset(input int i);
        k[i]      = 0;
        h1[i]     = '0;
        h2[i]     = '0;
        m_out[i]  = '0;
        m_rise[i] = '0;
        m_fall[i] = '0;
        for (int ch = 0; ch < 4; ch++) run_start[i][ch] = 0;
    endtask

    // Edge k after reset is a sample tick iff k is a multiple of p. The level seen at edge k
    // is In from edge k-2. A channel toggles once its current unbroken run of differing
    // samples has spanned st ticks.
    task automatic modelEdge(input int i, input logic [3:0] in_now, input int p, input int st);
        logic [3:0] s2;
        int ticks;
        k[i]      = k[i] + 1;
        s2        = h2[i];
        h2[i]     = h1[i];
        h1[i]     = in_now;
        m_rise[i] = '0;
        m_fall[i] = '0;
        for (int ch = 0; ch < 4; ch++) begin
            if (s2[ch] == m_out[i][ch]) begin
                run_start[i][ch] = 0;
            end else begin
                if (run_start[i][ch] == 0) run_start[i][ch] = k[i];
                ticks = k[i] / p - (run_start[i][ch] - 1) / p;
                if ((k[i] % p == 0) && (ticks == st)) begin
                    m_out[i][ch]     = s2[ch];
                    m_rise[i][ch]    = s2[ch];
                    m_fall[i][ch]    = ~s2[ch];
                    run_start[i][ch] = 0;
                end
            end
        end
    endtask

    // Advance the model on every clock edge, clearing it with reset.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            modelReset(0);
            modelReset(1);
        end else begin
            modelEdge(0, in_a, 1, 4);
            modelEdge(1, in_b, 5, 3);
        end
    end

    // Compare both instances against the model halfway through every cycle.
    always @(negedge Clk) begin
        if (checking) begin
            checkOutput("a_out",  out_a,  m_out[0]);
            checkOutput("a_rise", rise_a, m_rise[0]);
            checkOutput("a_fall", fall_a, m_fall[0]);
            checkOutput("b_out",  out_b,  m_out[1]);
            checkOutput("b_rise", rise_b, m_rise[1]);
            checkOutput("b_fall", fall_b, m_fall[1]);
        end
    end

    initial begin
        int found;
        int e;
        tests_run    = 0;
        tests_failed = 0;
        checking     = 1'b0;
        Rst          = 1'b0;
        in_a         = 4'hF;
        in_b         = 4'h0;
        #2 Rst = 1'b1;
        #1;
        checkOutput("reset_out",  out_a,  0);
        checkOutput("reset_rise", rise_a, 0);
        checkOutput("reset_fall", fall_a, 0);
        checking = 1'b1;
        waitEdge(2);
        checkOutput("reset_held_out", out_a, 0);

        // Release with In=F held: toggle on edge 6.
        @(posedge Clk);
        #3 Rst = 1'b0;
        waitEdge(5);
        checkOutput("release_e5_out", out_a, 4'h0);
        waitEdge(1);
        checkOutput("release_e6_out",  out_a,  4'hF);
        checkOutput("release_e6_rise", rise_a, 4'hF);
        waitEdge(1);
        checkOutput("release_e7_rise", rise_a, 4'h0);
        checkOutput("release_e7_out",  out_a,  4'hF);

        // Mid-count reset discards progress and clears outputs at once.
        applyStimulus(0, 4'h0);
        waitEdge(3);
        #2 Rst = 1'b1;
        #1;
        checkOutput("midreset_out",  out_a,  0);
        checkOutput("midreset_rise", rise_a, 0);
        checkOutput("midreset_fall", fall_a, 0);
        waitEdge(2);
        checkOutput("midreset_held_out", out_a, 0);
        @(posedge Clk);
        #3 Rst = 1'b0;
        waitEdge(8);
        checkOutput("after_reset_out", out_a, 0);

        // Clean rising and falling step on channel 0.
        applyStimulus(0, 4'b0001);
        waitEdge(5);
        checkOutput("step_e5_out", out_a, 4'b0000);
        waitEdge(1);
        checkOutput("step_e6_out",  out_a,  4'b0001);
        checkOutput("step_e6_rise", rise_a, 4'b0001);
        waitEdge(1);
        checkOutput("step_e7_rise", rise_a, 4'b0000);
        applyStimulus(0, 4'b0000);
        waitEdge(6);
        checkOutput("fall_e6_out",  out_a,  4'b0000);
        checkOutput("fall_e6_fall", fall_a, 4'b0001);
        waitEdge(1);
        checkOutput("fall_e7_fall", fall_a, 4'b0000);

        // Bounce on channel 1, settling high.
        applyStimulus(0, 4'b0010);
        applyStimulus(0, 4'b0000);
        applyStimulus(0, 4'b0010);
        applyStimulus(0, 4'b0000);
        applyStimulus(0, 4'b0010);
        waitEdge(5);
        checkOutput("bounce_e5_out", out_a, 4'b0000);
        waitEdge(1);
        checkOutput("bounce_e6_out",  out_a,  4'b0010);
        checkOutput("bounce_e6_rise", rise_a, 4'b0010);

        // Three-cycle glitch on channel 2 is rejected.
        applyStimulus(0, 4'b0110);
        applyStimulus(0, 4'b0110);
        applyStimulus(0, 4'b0110);
        applyStimulus(0, 4'b0010);
        waitEdge(10);
        checkOutput("glitch_out", out_a, 4'b0010);

        // Four-cycle pulse on channel 3 just qualifies, then falls back.
        applyStimulus(0, 4'b1010);
        applyStimulus(0, 4'b1010);
        applyStimulus(0, 4'b1010);
        applyStimulus(0, 4'b1010);
        applyStimulus(0, 4'b0010);
        waitEdge(2);
        checkOutput("pulse4_out",  out_a,  4'b1010);
        checkOutput("pulse4_rise", rise_a, 4'b1000);
        waitEdge(4);
        checkOutput("pulse4_back_out",  out_a,  4'b0010);
        checkOutput("pulse4_back_fall", fall_a, 4'b1000);

        // Simultaneous toggles on channels 1 and 3.
        applyStimulus(0, 4'b0000);
        waitEdge(10);
        checkOutput("simul_pre_out", out_a, 4'b0000);
        applyStimulus(0, 4'b1010);
        waitEdge(6);
        checkOutput("simul_out",  out_a,  4'b1010);
        checkOutput("simul_rise", rise_a, 4'b1010);
        checkOutput("simul_fall", fall_a, 4'b0000);

        // Prescaled instance: step on channel 3.
        applyStimulus(1, 4'b1000);
        found = 0;
        for (int i = 1; i <= 40; i++) begin
            waitEdge(1);
            if (out_b[3] && found == 0) found = i;
        end
        checkRange("presc_step_edge", found, 13, 17);

        applyStimulus(1, 4'b0000);
        waitEdge(25);
        checkOutput("presc_back_out", out_b, 4'b0000);

        // Step again with a one-cycle low glitch sampled on edge 9.
        applyStimulus(1, 4'b1000);
        waitEdge(8);
        #2 in_b = 4'b0000;
        @(posedge Clk);
        #3 in_b = 4'b1000;
        e = 9;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            waitEdge(1);
            e++;
            if (out_b[3] && found == 0) found = e;
        end
        checkRange("presc_glitch_edge", found, 22, 26);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
